vac_dds_source: RTL and testbench

- Digital sine source feeding the DAC that drives the Vac stimulus node (Vin) of the resistive divider under test.
- Phase-accumulator NCO with a host-loadable quarter-wave magnitude table, quadrant folding and amplitude scaling.
- Emits signed samples over a valid/ready handshake; stalls cleanly under DAC backpressure.

---
 rtl/vac_dds_if.sv | 12 +
 rtl/vac_dds_source.sv | 125 ++++++++++++
 tb/tb_vac_dds_source.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vac_dds_if.sv
// Sample stream from the DDS source to the DAC consumer.
// Transfer happens on a clk edge where out_valid & out_ready are both high.
interface vac_dds_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/vac_dds_source.sv
// Phase-accumulator sine source: quarter-wave table, quadrant folding, amplitude scaling.
// Optional phase dither LFSR is enabled by defining VAC_DDS_DITHER_EN.
module vac_dds_source #(
    parameter int PHASE_W = 32,
    parameter int TBL_AW  = 8,
    parameter int DATA_W  = 16,
    parameter int AMP_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [AMP_W-1:0]   amp,
    input  logic               tbl_we,
    input  logic [TBL_AW-1:0]  tbl_addr,
    input  logic [DATA_W-2:0]  tbl_data,
    vac_dds_if.master          st
);
    localparam int MAG_W  = DATA_W - 1;
    localparam int DITH_W = PHASE_W - 2 - TBL_AW;

    // Valid/ready: the output register is free when empty or being drained this edge;
    // when it is not free every stage holds, so nothing is dropped or duplicated.
    logic adv;
    logic ov_q, ov_d;
    assign adv = ~ov_q | st.out_ready;

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] p0_q, p0_d;
    logic [PHASE_W-1:0] dith;
    logic               v0_q, v0_d;

`ifdef VAC_DDS_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        dith   = '0;
        lfsr_d = lfsr_q;
        for (int k = 0; k < 16; k++) begin
            if (k < DITH_W) dith[k] = lfsr_q[k];
        end
        if (adv && en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign dith = '0;
`endif

    always_comb begin
        acc_d = acc_q;
        p0_d  = p0_q;
        v0_d  = v0_q;
        if (adv) begin
            v0_d = en;
            if (en) begin
                p0_d  = acc_q + phase_off + dith;
                acc_d = acc_q + ftw;
            end
        end
    end

    // Odd quadrants walk the quarter wave backwards; the upper half-cycle is negated.
    logic [1:0]        quad;
    logic [TBL_AW-1:0] idx, rd_addr;
    assign quad    = p0_q[PHASE_W-1 -: 2];
    assign idx     = p0_q[PHASE_W-3 -: TBL_AW];
    assign rd_addr = quad[0] ? ~idx : idx;

    logic [MAG_W-1:0] tbl_q [2**TBL_AW];
    logic [MAG_W-1:0] mag_q;
    logic             v1_q, sign1_q;

    always_ff @(posedge clk) begin
        if (tbl_we && !rst) tbl_q[tbl_addr] <= tbl_data;
        if (adv)            mag_q <= tbl_q[rd_addr];
    end

    logic [MAG_W+AMP_W-1:0]   prod;
    logic [MAG_W-1:0]         scaled;
    logic signed [DATA_W-1:0] out_q, out_d;
    assign prod   = mag_q * amp;
    assign scaled = prod[AMP_W +: MAG_W];

    always_comb begin
        out_d = out_q;
        ov_d  = ov_q;
        if (adv) begin
            ov_d  = v1_q;
            out_d = sign1_q ? -$signed({1'b0, scaled}) : $signed({1'b0, scaled});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            p0_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            acc_q <= acc_d;
            p0_q  <= p0_d;
            v0_q  <= v0_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            if (adv) begin
                v1_q    <= v0_q;
                sign1_q <= quad[1];
            end
        end
    end

    assign st.out_data  = out_q;
    assign st.out_valid = ov_q;

    logic unused_ok;
    assign unused_ok = ^{p0_q[DITH_W-1:0], prod[AMP_W-1:0]};
endmodule

// File: tb/tb_vac_dds_source.sv
// Bench for vac_dds_source: reset, single-sample vector table, streamed model checks,
// backpressure, wrap, mid-stream reset and table read-during-write.
module tb_vac_dds_source;
  localparam int PHASE_W = 32;
  localparam int TBL_AW  = 8;
  localparam int DATA_W  = 16;
  localparam int AMP_W   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] ftw;
  logic [31:0] phase_off;
  logic [15:0] amp;
  logic        tbl_we;
  logic [7:0]  tbl_addr;
  logic [14:0] tbl_data;

  always #5 clk = ~clk;

  vac_dds_if #(.DATA_W(DATA_W)) st ();

  vac_dds_source #(
    .PHASE_W(PHASE_W), .TBL_AW(TBL_AW), .DATA_W(DATA_W), .AMP_W(AMP_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ftw(ftw), .phase_off(phase_off), .amp(amp),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .st(st)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];
  int tbl_m[256];

  typedef struct {
    logic [31:0] phase_off;
    logic [15:0] amp;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_tbl(input int addr, input int data);
    tbl_we   = 1'b1;
    tbl_addr = 8'(addr);
    tbl_data = 15'(data);
    tick();
    tbl_we   = 1'b0;
    tbl_m[addr] = data;
  endtask

  // Sine sample for a full phase word, straight from the quadrant rules.
  function automatic logic [15:0] model_sample(input logic [31:0] p, input logic [15:0] a);
    int q, i, idx, s;
    longint m;
    q   = int'(p >> 30);
    i   = int'((p >> 22) & 32'hFF);
    idx = (q % 2 == 1) ? 255 - i : i;
    m   = longint'(tbl_m[idx]) * longint'(a);
    s   = int'(m / 65536);
    if (q >= 2) s = -s;
    return 16'(s);
  endfunction

  // Streams from a fresh reset; sample n of the stream is at phase phase_off + n*ftw.
  task automatic run_stream(input string tag, input int n_samp, input bit rnd_ready,
                            input int stall_at, input int wr_at, input int wr_addr,
                            input int wr_data, output int cycles);
    int got = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [15:0] pd = '0;
    logic r;
    logic [31:0] ph;
    exp_q.delete();
    // The write lands many samples before its address is first looked up.
    if (wr_at >= 0) tbl_m[wr_addr] = wr_data;
    for (int n = 0; n < n_samp; n++) begin
      ph = phase_off + 32'(n) * ftw;
      exp_q.push_back(model_sample(ph, amp));
    end
    do_reset();
    en = 1'b1;
    while (got < n_samp && cyc < n_samp * 6 + 50) begin
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) r = 1'b0;
      else if (rnd_ready) r = ($urandom_range(0, 3) != 0);
      else r = 1'b1;
      st.out_ready = r;
      if (pv && !pr) begin
        check({tag, "_hold_valid"}, {31'b0, st.out_valid}, 32'd1);
        check({tag, "_hold_data"}, {16'b0, st.out_data}, {16'b0, pd});
      end
      if (st.out_valid && r) begin
        check($sformatf("%s_sample%0d", tag, got), {16'b0, st.out_data}, {16'b0, exp_q.pop_front()});
        got++;
      end
      if (cyc == wr_at) begin
        tbl_we   = 1'b1;
        tbl_addr = 8'(wr_addr);
        tbl_data = 15'(wr_data);
      end else begin
        tbl_we = 1'b0;
      end
      pv = st.out_valid;
      pr = r;
      pd = st.out_data;
      tick();
      cyc++;
    end
    tbl_we = 1'b0;
    en = 1'b0;
    st.out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(n_samp));
    cycles = cyc;
  endtask

  initial begin
    int lat;
    int cycles;
    logic [15:0] wrap_exp[4];

    vecs[0] = '{32'h0000_0000, 16'hFFFF, 16'h0000};
    vecs[1] = '{32'h4000_0000, 16'hFFFF, 16'h7F7F};
    vecs[2] = '{32'h8140_0000, 16'hFFFF, 16'hFD81};
    vecs[3] = '{32'hC280_0000, 16'hFFFF, 16'h8581};
    vecs[4] = '{32'h1900_0000, 16'h8000, 16'h1900};
    vecs[5] = '{32'h4000_0000, 16'h0000, 16'h0000};
    vecs[6] = '{32'h4000_0000, 16'h0001, 16'h0000};
    vecs[7] = '{32'h4040_0000, 16'h4000, 16'h1FC0};
    vecs[8] = '{32'h00FF_FFFF, 16'hFFFF, 16'h017F};
    wrap_exp[0] = 16'h0000;
    wrap_exp[1] = 16'hFF81;
    wrap_exp[2] = 16'h00FF;
    wrap_exp[3] = 16'hFE81;

    rst = 1'b1; en = 1'b0; ftw = '0; phase_off = '0; amp = 16'hFFFF;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; st.out_ready = 1'b1;
    tick();
    tick();
    check("reset_valid", {31'b0, st.out_valid}, 32'd0);
    check("reset_data", {16'b0, st.out_data}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 256; k++) write_tbl(k, k * 128);

    // Single-sample vectors: ftw = 0, so every issue carries the same phase.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      ftw = '0; phase_off = vecs[v].phase_off; amp = vecs[v].amp; en = 1'b1;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!st.out_valid && lat < 10);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("vec%0d_data", v), {16'b0, st.out_data}, {16'b0, vecs[v].exp_data});
      en = 1'b0;
    end

    ftw = 32'h0040_0000; phase_off = '0; amp = 16'hFFFF;
    run_stream("ramp", 1030, 1'b0, -1, -1, 0, 0, cycles);
    check("ramp_cadence", 32'(cycles), 32'd1033);

    amp = 16'h0000;
    run_stream("amp0", 40, 1'b0, -1, -1, 0, 0, cycles);
    check("amp0_cadence", 32'(cycles), 32'd43);

    amp = 16'hFFFF;
    run_stream("bp", 40, 1'b0, 12, -1, 0, 0, cycles);
    run_stream("rnd", 1100, 1'b1, 100, 10, 200, 16'h7000, cycles);

    do_reset();
    ftw = 32'h8040_0000; phase_off = '0; amp = 16'hFFFF; en = 1'b1; st.out_ready = 1'b1;
    tick(); tick(); tick();
    for (int n = 0; n < 4; n++) begin
      check($sformatf("wrap%0d", n), {16'b0, st.out_data}, {16'b0, wrap_exp[n]});
      tick();
    end
    en = 1'b0;

    // Mid-stream reset, also attempting a table write that must be ignored.
    do_reset();
    ftw = 32'h0040_0000; phase_off = 32'h4000_0000; en = 1'b1;
    tick(); tick(); tick();
    check("restart_first_a", {16'b0, st.out_data}, 32'h7F7F);
    tick(); tick(); tick();
    rst = 1'b1; tbl_we = 1'b1; tbl_addr = 8'd255; tbl_data = 15'h1234;
    tick();
    check("midrst_valid", {31'b0, st.out_valid}, 32'd0);
    check("midrst_data", {16'b0, st.out_data}, 32'd0);
    rst = 1'b0; tbl_we = 1'b0;
    tick(); tick(); tick();
    check("restart_valid", {31'b0, st.out_valid}, 32'd1);
    check("restart_first_b", {16'b0, st.out_data}, 32'h7F7F);
    en = 1'b0;

    // Continuous lookups of entry 7 while it is rewritten.
    do_reset();
    ftw = '0; phase_off = 32'h01C0_0000; amp = 16'hFFFF; en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("rdw_before", {16'b0, st.out_data}, 32'd895);
    tbl_we = 1'b1; tbl_addr = 8'd7; tbl_data = 15'd256;
    tick();
    tbl_we = 1'b0;
    tick();
    check("rdw_old", {16'b0, st.out_data}, 32'd895);
    tick();
    check("rdw_new", {16'b0, st.out_data}, 32'd255);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
